// File: rtl/pbl_input_cond.sv
// -----------------------------------------------------------------------------
// pbl_input_cond
// Input conditioning for the board slide switches and push buttons. Every raw
// input is synchronized into the CLK domain and then debounced: the debounced
// level only follows the synchronized level once the two have disagreed for
// DB_CYCLES consecutive clock cycles.
//
// Ports
//   CLK                       clock, rising edge
//   RST_N                     asynchronous active-low reset
//   CH7_RAW..CH4_RAW          raw slide switches, active-high, asynchronous
//   B3_N_RAW, B2_N_RAW        raw push buttons, active-low, asynchronous
//   CH7..CH4                  debounced switch levels
//   B3, B2                    debounced button levels, active-high
//   PRESS_B3, PRESS_B2        one-cycle pulse after a debounced press
//   CHG                       one-cycle pulse after any debounced change
//   VALID                     no channel has a change pending
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pbl_input_cond #(
  parameter int DB_CYCLES = 50000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CH7_RAW,
  input  logic CH6_RAW,
  input  logic CH5_RAW,
  input  logic CH4_RAW,
  input  logic B3_N_RAW,
  input  logic B2_N_RAW,
  output logic CH7,
  output logic CH6,
  output logic CH5,
  output logic CH4,
  output logic B3,
  output logic B2,
  output logic PRESS_B3,
  output logic PRESS_B2,
  output logic CHG,
  output logic VALID
);

  localparam int NCH = 6;
  localparam int CW  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  // Channel order: [5]=CH7 [4]=CH6 [3]=CH5 [2]=CH4 [1]=B3 [0]=B2.
  // Buttons are inverted up front so every channel is active-high and the
  // reset value 0 of the synchronizer means "released".
  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] sync_s;     // synchronized level s
  logic [NCH-1:0] db_q;       // debounced level d
  logic [NCH-1:0] upd;        // d changes on this edge
  logic [NCH-1:0] db_d;

  assign raw_in = {CH7_RAW, CH6_RAW, CH5_RAW, CH4_RAW, ~B3_N_RAW, ~B2_N_RAW};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic          meta_q;
      logic          sync_q;
      logic          deb_q;
      logic          deb_d;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync_q != deb_q) begin
          if (cnt_q == CNT_MAX) begin
            deb_d = sync_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
          deb_q  <= 1'b0;
          cnt_q  <= '0;
        end else begin
          meta_q <= raw_in[gi];
          sync_q <= meta_q;
          deb_q  <= deb_d;
          cnt_q  <= cnt_d;
        end
      end

      assign sync_s[gi] = sync_q;
      assign db_q[gi]   = deb_q;
      assign db_d[gi]   = deb_d;
      assign upd[gi]    = deb_d ^ deb_q;
    end
  endgenerate

  // Event pulses are registered off the same edge that updates d, so they are
  // high for the cycle right after the change. A press is an update whose new
  // level is 1.
  logic       chg_q;
  logic [1:0] press_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chg_q   <= 1'b0;
      press_q <= 2'b00;
    end else begin
      chg_q   <= |upd;
      press_q <= upd[1:0] & db_d[1:0];
    end
  end

  assign {CH7, CH6, CH5, CH4, B3, B2} = db_q;
  assign PRESS_B3 = press_q[1];
  assign PRESS_B2 = press_q[0];
  assign CHG      = chg_q;
  assign VALID    = ~|(sync_s ^ db_q);

endmodule
